// File: rtl/count_chk_pkg.sv
// Shared types and default geometry for the count_checker slice.
// Default build widths match the common 4-bit counter use.
package count_chk_pkg;

  localparam int CHK_WIDTH     = 4;
  localparam int CHK_ERR_CNT_W = 8;
  localparam int CHK_SYNC_LEN  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2,
    ERR  = 2'd3
  } chk_state_t;

endpackage

// File: rtl/count_chk_sat_ctr.sv
// Saturating up-counter: holds at all-ones, synchronous clear wins over increment.
// Latency: value reflects inc/clr one edge later.
// Backpressure: none; inc is a single-cycle strobe.
module count_chk_sat_ctr #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && !(&value)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/count_checker.sv
// Passive monitor that predicts an enable-gated up-counter, locks on, and flags mismatches.
// Latency: outputs registered, one edge after the observed sample; lock needs SYNC_LEN+1 edges.
// Backpressure: none (observe-only); wrap counting built only with COUNT_CHK_WRAP_EN.
module count_checker
  import count_chk_pkg::*;
#(
  parameter int WIDTH     = CHK_WIDTH,
  parameter int ERR_CNT_W = CHK_ERR_CNT_W,
  parameter int SYNC_LEN  = CHK_SYNC_LEN
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cnt_reset,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     count_in,
  input  logic                 clear,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ERR_CNT_W-1:0] wrap_count
);

  localparam int MC_W = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(SYNC_LEN - 1);

  chk_state_t       state;
  logic [WIDTH-1:0] h_cnt;
  logic             h_en;
  logic             h_rst;
  logic [MC_W-1:0]  match_cnt;
  logic [WIDTH-1:0] pred;
  logic             match;
  logic             err_inc;

  // Counter reset outranks enable, exactly as in the observed counter.
  always_comb begin
    pred = h_cnt;
    if (h_rst) begin
      pred = '0;
    end else if (h_en) begin
      pred = h_cnt + 1'b1;
    end
  end

  assign match   = (count_in == pred);
  assign err_inc = (state == LOCK) && !match && !clear;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      h_cnt     <= '0;
      h_en      <= 1'b0;
      h_rst     <= 1'b0;
      match_cnt <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      h_cnt     <= count_in;
      h_en      <= enable;
      h_rst     <= cnt_reset;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      if (clear) begin
        state     <= IDLE;
        match_cnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            state     <= SYNC;
            match_cnt <= '0;
          end
          SYNC: begin
            if (!match) begin
              match_cnt <= '0;
            end else if (match_cnt == MC_LAST) begin
              state     <= LOCK;
              locked    <= 1'b1;
              match_cnt <= '0;
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end
          LOCK: begin
            if (match) begin
              locked <= 1'b1;
            end else begin
              state     <= ERR;
              err_pulse <= 1'b1;
            end
          end
          ERR: begin
            state     <= SYNC;
            match_cnt <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  count_chk_sat_ctr #(.WIDTH(ERR_CNT_W)) u_err_ctr (
    .clock (clock),
    .reset (reset),
    .inc   (err_inc),
    .clr   (clear),
    .value (err_count)
  );

`ifdef COUNT_CHK_WRAP_EN
  logic wrap_inc;

  // A verified wrap is a matched increment out of the all-ones value while locked.
  assign wrap_inc = (state == LOCK) && h_en && !h_rst && (&h_cnt) && match && !clear;

  count_chk_sat_ctr #(.WIDTH(ERR_CNT_W)) u_wrap_ctr (
    .clock (clock),
    .reset (reset),
    .inc   (wrap_inc),
    .clr   (clear),
    .value (wrap_count)
  );
`else
  assign wrap_count = '0;
`endif

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker (WIDTH=4, SYNC_LEN=2, ERR_CNT_W=8).
module tb_count_checker;

  logic       clock = 1'b0;
  logic       reset;
  logic       cnt_reset;
  logic       enable;
  logic [3:0] count_in;
  logic       clear;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_count;
  logic [7:0] wrap_count;

  logic [3:0] cnt_m;
  int         n_pass = 0;
  int         n_total = 0;

`ifdef COUNT_CHK_WRAP_EN
  localparam logic [7:0] EXP_WRAP = 8'd1;
`else
  localparam logic [7:0] EXP_WRAP = 8'd0;
`endif

  count_checker #(.WIDTH(4), .ERR_CNT_W(8), .SYNC_LEN(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .cnt_reset  (cnt_reset),
    .enable     (enable),
    .count_in   (count_in),
    .clear      (clear),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .wrap_count (wrap_count)
  );

  always #5 clock = ~clock;

  // One edge of a well-behaved counter; inputs change and outputs are read 1ns after the edge.
  task automatic step(input logic en, input logic rst);
    enable    = en;
    cnt_reset = rst;
    count_in  = cnt_m;
    @(posedge clock);
    #1;
    if (rst) cnt_m = 4'd0;
    else if (en) cnt_m = cnt_m + 4'd1;
    count_in = cnt_m;
  endtask

  // Counter jumps one value ahead of the prediction on this edge, then counts on from there.
  task automatic glitch();
    cnt_m     = cnt_m + 4'd1;
    count_in  = cnt_m;
    enable    = 1'b1;
    cnt_reset = 1'b0;
    @(posedge clock);
    #1;
    cnt_m    = cnt_m + 4'd1;
    count_in = cnt_m;
  endtask

  task automatic lock_up(output logic ok);
    for (int i = 0; i < 8 && !locked; i++) step(1'b1, 1'b0);
    ok = locked;
  endtask

  task automatic test_reset();
    reset = 1'b0; cnt_reset = 1'b0; enable = 1'b0; clear = 1'b0;
    cnt_m = 4'd0; count_in = 4'd0;
    repeat (3) @(posedge clock);
    #1;
    n_total++;
    if ({locked, err_pulse, err_count, wrap_count} !== 18'd0)
      $display("FAIL reset_state: got locked=%b pulse=%b err=%0d wrap=%0d, want all 0",
               locked, err_pulse, err_count, wrap_count);
    else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_lock_wrap();
    for (int s = 1; s <= 17; s++) begin
      step(1'b1, 1'b0);
      if (s == 2) begin
        n_total++;
        if (locked !== 1'b0) $display("FAIL lock_edge2: got locked=%b, want 0", locked);
        else n_pass++;
      end
      if (s == 3) begin
        n_total++;
        if (locked !== 1'b1) $display("FAIL lock_edge3: got locked=%b, want 1", locked);
        else n_pass++;
      end
    end
    n_total++;
    if (locked !== 1'b1 || err_count !== 8'd0)
      $display("FAIL clean_run: got locked=%b err=%0d, want 1/0", locked, err_count);
    else n_pass++;
    n_total++;
    if (wrap_count !== EXP_WRAP)
      $display("FAIL wrap_count: got %0d, want %0d", wrap_count, EXP_WRAP);
    else n_pass++;
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 16 && cnt_m != 4'd6; i++) step(1'b1, 1'b0);
    glitch();
    n_total++;
    if (err_pulse !== 1'b1 || locked !== 1'b0 || err_count !== 8'd1)
      $display("FAIL glitch_detect: got pulse=%b locked=%b err=%0d, want 1/0/1",
               err_pulse, locked, err_count);
    else n_pass++;
    step(1'b1, 1'b0);
    n_total++;
    if (err_pulse !== 1'b0 || locked !== 1'b0)
      $display("FAIL glitch_pulse_width: got pulse=%b locked=%b, want 0/0", err_pulse, locked);
    else n_pass++;
    step(1'b1, 1'b0);
    n_total++;
    if (locked !== 1'b0) $display("FAIL relock_early: got locked=%b, want 0", locked);
    else n_pass++;
    step(1'b1, 1'b0);
    n_total++;
    if (locked !== 1'b1 || err_count !== 8'd1)
      $display("FAIL relock: got locked=%b err=%0d, want 1/1", locked, err_count);
    else n_pass++;
  endtask

  task automatic test_stall_reset();
    logic bad;
    bad = 1'b0;
    step(1'b1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0);
      if (locked !== 1'b1 || err_pulse !== 1'b0) bad = 1'b1;
    end
    n_total++;
    if (cnt_m !== 4'd9 || bad !== 1'b0)
      $display("FAIL count_to_9: got cnt=%0d lost_lock=%b, want 9/0", cnt_m, bad);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      n_total++;
      if (locked !== 1'b1 || err_pulse !== 1'b0)
        $display("FAIL stall_%0d: got locked=%b pulse=%b, want 1/0", i, locked, err_pulse);
      else n_pass++;
    end
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    n_total++;
    if (locked !== 1'b1 || err_pulse !== 1'b0 || err_count !== 8'd1)
      $display("FAIL cnt_reset_prio: got locked=%b pulse=%b err=%0d, want 1/0/1",
               locked, err_pulse, err_count);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    #3;
    reset = 1'b0;
    #1;
    n_total++;
    if ({locked, err_pulse, err_count, wrap_count} !== 18'd0)
      $display("FAIL async_reset: got locked=%b pulse=%b err=%0d wrap=%0d, want all 0",
               locked, err_pulse, err_count, wrap_count);
    else n_pass++;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_clear();
    logic ok;
    lock_up(ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL clear_prelock: got locked=%b, want 1", ok);
    else n_pass++;
    glitch();
    lock_up(ok);
    n_total++;
    if (ok !== 1'b1 || err_count !== 8'd1)
      $display("FAIL clear_setup: got locked=%b err=%0d, want 1/1", ok, err_count);
    else n_pass++;
    clear = 1'b1;
    glitch();
    clear = 1'b0;
    n_total++;
    if (err_pulse !== 1'b0 || locked !== 1'b0 || err_count !== 8'd0)
      $display("FAIL clear_vs_mismatch: got pulse=%b locked=%b err=%0d, want 0/0/0",
               err_pulse, locked, err_count);
    else n_pass++;
    // From IDLE the relock takes three edges; from SYNC it would take two.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    n_total++;
    if (locked !== 1'b0) $display("FAIL clear_to_idle: got locked=%b, want 0", locked);
    else n_pass++;
    step(1'b1, 1'b0);
    n_total++;
    if (locked !== 1'b1) $display("FAIL clear_relock: got locked=%b, want 1", locked);
    else n_pass++;
  endtask

  task automatic test_saturation();
    logic [7:0] exp_err;
    for (int i = 0; i < 256; i++) begin
      exp_err = (i >= 254) ? 8'd255 : 8'(i + 1);
      glitch();
      n_total++;
      if (err_pulse !== 1'b1 || err_count !== exp_err)
        $display("FAIL sat_%0d: got pulse=%b err=%0d, want 1/%0d", i, err_pulse, err_count, exp_err);
      else n_pass++;
      repeat (3) step(1'b1, 1'b0);
    end
    n_total++;
    if (err_count !== 8'd255 || wrap_count !== 8'd0)
      $display("FAIL sat_final: got err=%0d wrap=%0d, want 255/0", err_count, wrap_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lock_wrap();
    test_glitch();
    test_stall_reset();
    test_async_reset();
    test_clear();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
